pcie_rst_seq: RTL and testbench

- Parametrised PCIe reset and bring-up sequencer for the example-design top level.
- Merges any number of PERST# sources (pin and GPIO) into one reset request.
- Releases the transceiver PLL, per-lane TX/RX, core and application resets in a fixed staged order.
- Adds lane-count generalisation, per-stage timeouts, bounded retry, loss-of-lock recovery and a fault state.

---
 rtl/pcie_rst_pkg.sv | 22 ++
 rtl/pcie_rst_seq_perst_sync.sv | 57 +++++
 rtl/pcie_rst_seq.sv | 184 ++++++++++++++++++
 tb/tb_pcie_rst_seq.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_rst_pkg.sv
// Shared types and helpers for the PCIe reset/bring-up sequencer.
package pcie_rst_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PLL_RST  = 3'd1,
      ST_PLL_WAIT = 3'd2,
      ST_TX_WAIT  = 3'd3,
      ST_RX_WAIT  = 3'd4,
      ST_CORE     = 3'd5,
      ST_RUN      = 3'd6,
      ST_FAULT    = 3'd7
   } seq_state_t;

   // Width of a state timer that must be able to reach the larger of two limits.
   function automatic int timer_width(input int lim_a, input int lim_b);
      int lim_max;
      lim_max = (lim_a > lim_b) ? lim_a : lim_b;
      return $clog2(lim_max + 1);
   endfunction

endpackage

// File: rtl/pcie_rst_seq_perst_sync.sv
// PERST# merge: per-source synchroniser, masked OR into one request, and a
// debounce counter that qualifies the release.
module pcie_rst_seq_perst_sync
   import pcie_rst_pkg::*;
#(
   parameter int NUM_PERST       = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset,
   input  logic [NUM_PERST-1:0] perst_n_in,
   input  logic [NUM_PERST-1:0] perst_mask,
   output logic                 perst_req,
   output logic                 perst_release
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [NUM_PERST-1:0] sync_q [SYNC_STAGES];
   logic [NUM_PERST-1:0] sync_d [SYNC_STAGES];
   logic [DW-1:0]        deb_q;
   logic [DW-1:0]        deb_d;

   // Shift the synchroniser, merge enabled sources, count quiet cycles.
   always_comb begin
      sync_d[0] = perst_n_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      perst_req = |(perst_mask & ~sync_q[SYNC_STAGES-1]);
      if (perst_req) begin
         deb_d = '0;
      end else if (deb_q != DW'(DEBOUNCE_CYCLES)) begin
         deb_d = deb_q + 1'b1;
      end else begin
         deb_d = deb_q;
      end
      perst_release = (deb_q == DW'(DEBOUNCE_CYCLES));
   end

   // Synchroniser resets to "PERST# asserted" so release always needs a full debounce.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         deb_q <= '0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         deb_q <= deb_d;
      end
   end

endmodule

// File: rtl/pcie_rst_seq.sv
// PCIe reset and bring-up sequencer: staged release of PLL, lane TX/RX, core
// and application resets with per-stage timeouts, bounded retry and recovery.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | everything in reset, waiting for debounced PERST# release
//   PLL_RST  | pll_reset pulse of PLL_RST_CYCLES
//   PLL_WAIT | waiting for pll_locked
//   TX_WAIT  | enabled TX lanes released, waiting for lane_tx_ready
//   RX_WAIT  | enabled RX lanes released, waiting for lane_cdr_locked
//   CORE     | core released for one cycle
//   RUN      | application released, watching for loss of lock
//   FAULT    | retries exhausted; left only via PERST# or reset_reset
//
// TX_WAIT and RX_WAIT hold their lane resets on the entry cycle and only judge
// readiness afterwards, so re-entering RX_WAIT from RUN always pulses RX reset.
module pcie_rst_seq
   import pcie_rst_pkg::*;
#(
   parameter int NUM_PERST       = 2,
   parameter int NUM_LANES       = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int PLL_RST_CYCLES  = 16,
   parameter int STAGE_TIMEOUT   = 1024,
   parameter int MAX_RETRIES     = 3
) (
   input  logic                               clk_clk,
   input  logic                               reset_reset,
   input  logic [NUM_PERST-1:0]               perst_n_in,
   input  logic [NUM_PERST-1:0]               perst_mask,
   input  logic [NUM_LANES-1:0]               lane_en,
   input  logic                               pll_locked,
   input  logic [NUM_LANES-1:0]               lane_tx_ready,
   input  logic [NUM_LANES-1:0]               lane_cdr_locked,
   output logic                               pll_reset,
   output logic [NUM_LANES-1:0]               lane_tx_reset,
   output logic [NUM_LANES-1:0]               lane_rx_reset,
   output logic                               core_reset,
   output logic                               app_reset,
   output logic [2:0]                         seq_state,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
   output logic                               fault
);

   localparam int TW = timer_width(PLL_RST_CYCLES, STAGE_TIMEOUT);
   localparam int RW = $clog2(MAX_RETRIES + 1);

   logic perst_req;
   logic perst_release;

   pcie_rst_seq_perst_sync #(
      .NUM_PERST       (NUM_PERST),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_perst_sync (
      .clk_clk       (clk_clk),
      .reset_reset   (reset_reset),
      .perst_n_in    (perst_n_in),
      .perst_mask    (perst_mask),
      .perst_req     (perst_req),
      .perst_release (perst_release)
   );

   seq_state_t           state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [RW-1:0]        retry_q, retry_d;
   logic                 pll_reset_q, pll_reset_d;
   logic [NUM_LANES-1:0] tx_reset_q, tx_reset_d;
   logic [NUM_LANES-1:0] rx_reset_q, rx_reset_d;
   logic                 core_reset_q, core_reset_d;
   logic                 app_reset_q, app_reset_d;
   logic                 fault_q, fault_d;

   logic all_tx_ready;
   logic all_cdr_locked;
   logic timer_started;
   logic timer_expired;
   logic take_timeout;

   assign all_tx_ready   = &(lane_tx_ready | ~lane_en);
   assign all_cdr_locked = &(lane_cdr_locked | ~lane_en);
   assign timer_started  = (timer_q != '0);
   assign timer_expired  = (timer_q == TW'(STAGE_TIMEOUT));

   // Next state with priority PERST# > loss of lock > timeout > progress.
   always_comb begin
      state_d      = state_q;
      retry_d      = retry_q;
      take_timeout = 1'b0;
      if (perst_req) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:     if (perst_release) state_d = ST_PLL_RST;
            ST_PLL_RST:  if (timer_q == TW'(PLL_RST_CYCLES - 1)) state_d = ST_PLL_WAIT;
            ST_PLL_WAIT: begin
               if (pll_locked)         state_d = ST_TX_WAIT;
               else if (timer_expired) take_timeout = 1'b1;
            end
            ST_TX_WAIT: begin
               if (all_tx_ready && timer_started) state_d = ST_RX_WAIT;
               else if (timer_expired)            take_timeout = 1'b1;
            end
            ST_RX_WAIT: begin
               if (all_cdr_locked && timer_started) state_d = ST_CORE;
               else if (timer_expired)              take_timeout = 1'b1;
            end
            ST_CORE:     state_d = ST_RUN;
            ST_RUN: begin
               if (!pll_locked)          state_d = ST_PLL_RST;
               else if (!all_cdr_locked) state_d = ST_RX_WAIT;
            end
            ST_FAULT:    state_d = ST_FAULT;
            default:     state_d = ST_IDLE;
         endcase
      end
      if (take_timeout) begin
         if (retry_q == RW'(MAX_RETRIES)) begin
            state_d = ST_FAULT;
         end else begin
            retry_d = retry_q + 1'b1;
            state_d = ST_PLL_RST;
         end
      end
      if (state_d == ST_IDLE) retry_d = '0;
      if (state_d != state_q)       timer_d = '0;
      else if (timer_q == '1)       timer_d = timer_q;
      else                          timer_d = timer_q + 1'b1;
   end

   // Output values for the next state, so the registered outputs track seq_state.
   always_comb begin
      pll_reset_d  = !(state_d inside {ST_PLL_WAIT, ST_TX_WAIT, ST_RX_WAIT, ST_CORE, ST_RUN});
      tx_reset_d   = '1;
      rx_reset_d   = '1;
      if ((state_d == ST_TX_WAIT && timer_d != '0) ||
          (state_d inside {ST_RX_WAIT, ST_CORE, ST_RUN})) begin
         tx_reset_d = ~lane_en;
      end
      if ((state_d == ST_RX_WAIT && timer_d != '0) ||
          (state_d inside {ST_CORE, ST_RUN})) begin
         rx_reset_d = ~lane_en;
      end
      core_reset_d = !(state_d inside {ST_CORE, ST_RUN});
      app_reset_d  = (state_d != ST_RUN);
      fault_d      = (state_d == ST_FAULT);
   end

   // Sequencer state, timer, retry counter and registered outputs.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         retry_q      <= '0;
         pll_reset_q  <= 1'b1;
         tx_reset_q   <= '1;
         rx_reset_q   <= '1;
         core_reset_q <= 1'b1;
         app_reset_q  <= 1'b1;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         retry_q      <= retry_d;
         pll_reset_q  <= pll_reset_d;
         tx_reset_q   <= tx_reset_d;
         rx_reset_q   <= rx_reset_d;
         core_reset_q <= core_reset_d;
         app_reset_q  <= app_reset_d;
         fault_q      <= fault_d;
      end
   end

   assign pll_reset     = pll_reset_q;
   assign lane_tx_reset = tx_reset_q;
   assign lane_rx_reset = rx_reset_q;
   assign core_reset    = core_reset_q;
   assign app_reset     = app_reset_q;
   assign seq_state     = state_q;
   assign retry_count   = retry_q;
   assign fault         = fault_q;

endmodule

// File: tb/tb_pcie_rst_seq.sv
// Bench for pcie_rst_seq: per-cycle reference model, a vector table of lane and
// mask configurations, directed corner-case sequences and a randomized phase.
module tb_pcie_rst_seq;

   localparam int NP = 2;
   localparam int NL = 4;
   localparam int SS = 2;
   localparam int DB = 8;
   localparam int PR = 16;
   localparam int TO = 1024;
   localparam int MR = 3;

   logic          clk = 1'b0;
   logic          reset_reset;
   logic [NP-1:0] perst_n_in;
   logic [NP-1:0] perst_mask;
   logic [NL-1:0] lane_en;
   logic          pll_locked;
   logic [NL-1:0] lane_tx_ready;
   logic [NL-1:0] lane_cdr_locked;
   logic          pll_reset;
   logic [NL-1:0] lane_tx_reset;
   logic [NL-1:0] lane_rx_reset;
   logic          core_reset;
   logic          app_reset;
   logic [2:0]    seq_state;
   logic [1:0]    retry_count;
   logic          fault;

   always #5 clk = ~clk;

   pcie_rst_seq #(
      .NUM_PERST(NP), .NUM_LANES(NL), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
      .PLL_RST_CYCLES(PR), .STAGE_TIMEOUT(TO), .MAX_RETRIES(MR)
   ) dut (
      .clk_clk(clk), .reset_reset(reset_reset), .perst_n_in(perst_n_in),
      .perst_mask(perst_mask), .lane_en(lane_en), .pll_locked(pll_locked),
      .lane_tx_ready(lane_tx_ready), .lane_cdr_locked(lane_cdr_locked),
      .pll_reset(pll_reset), .lane_tx_reset(lane_tx_reset), .lane_rx_reset(lane_rx_reset),
      .core_reset(core_reset), .app_reset(app_reset), .seq_state(seq_state),
      .retry_count(retry_count), .fault(fault)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: stage number, cycles spent in it, retries, quiet count.
   int            m_stage, m_t, m_retries, m_quiet;
   logic [NP-1:0] m_hist[$];
   logic [31:0]   exp_vec;
   logic [31:0]   reset_vec;
   logic [23:0]   trace_v;
   logic [2:0]    prev_state;

   typedef struct {
      logic [NP-1:0] mask;
      logic [NL-1:0] en;
      logic [NL-1:0] rdy;
      logic [2:0]    exp_state;
      logic [NL-1:0] exp_tx;
      logic [NL-1:0] exp_rx;
      logic          exp_app;
   } vec_t;

   vec_t vectors[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] dut_vec();
      return {15'd0, pll_reset, lane_tx_reset, lane_rx_reset, core_reset, app_reset,
              seq_state, retry_count, fault};
   endfunction

   // One clock edge of the behaviour, evaluated from the inputs present at the edge.
   task automatic model_step();
      logic [NP-1:0] sync_n;
      logic [NL-1:0] all_ones;
      bit req, rel, tx_ok, cdr_ok, tmo, tx_rel, rx_rel;
      int nxt;
      all_ones = '1;
      if (reset_reset) begin
         m_stage = 0; m_t = 0; m_retries = 0; m_quiet = 0;
         m_hist = {};
         for (int i = 0; i < SS; i++) m_hist.push_back('0);
      end else begin
         sync_n = m_hist.pop_front();
         m_hist.push_back(perst_n_in);
         req     = |(perst_mask & ~sync_n);
         rel     = (m_quiet >= DB);
         m_quiet = req ? 0 : ((m_quiet < DB) ? m_quiet + 1 : DB);
         tx_ok   = ((lane_tx_ready | ~lane_en) == all_ones);
         cdr_ok  = ((lane_cdr_locked | ~lane_en) == all_ones);
         nxt = m_stage;
         tmo = 0;
         if (req) nxt = 0;
         else begin
            case (m_stage)
               0: if (rel) nxt = 1;
               1: if (m_t == PR - 1) nxt = 2;
               2: if (pll_locked) nxt = 3; else if (m_t == TO) tmo = 1;
               3: if (tx_ok && m_t > 0) nxt = 4; else if (m_t == TO) tmo = 1;
               4: if (cdr_ok && m_t > 0) nxt = 5; else if (m_t == TO) tmo = 1;
               5: nxt = 6;
               6: if (!pll_locked) nxt = 1; else if (!cdr_ok) nxt = 4;
               default: nxt = m_stage;
            endcase
         end
         if (tmo) begin
            if (m_retries == MR) nxt = 7;
            else begin m_retries++; nxt = 1; end
         end
         if (nxt == 0) m_retries = 0;
         m_t = (nxt != m_stage) ? 0 : m_t + 1;
         m_stage = nxt;
      end
      tx_rel = (m_stage >= 4 && m_stage <= 6) || (m_stage == 3 && m_t > 0);
      rx_rel = (m_stage == 5 || m_stage == 6) || (m_stage == 4 && m_t > 0);
      exp_vec = {15'd0,
                 1'(!(m_stage >= 2 && m_stage <= 6)),
                 tx_rel ? ~lane_en : all_ones,
                 rx_rel ? ~lane_en : all_ones,
                 1'(!(m_stage == 5 || m_stage == 6)),
                 1'(m_stage != 6),
                 3'(m_stage), 2'(m_retries), 1'(m_stage == 7)};
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check("model", dut_vec(), exp_vec);
      if (seq_state != prev_state) trace_v = {trace_v[20:0], seq_state};
      prev_state = seq_state;
   endtask

   task automatic do_reset();
      reset_reset = 1'b1;
      repeat (3) cyc();
      reset_reset = 1'b0;
      trace_v = '0;
      prev_state = 3'd0;
   endtask

   task automatic wait_state(input logic [2:0] st, input int budget, input string name);
      int n = 0;
      while (seq_state != st && n < budget) begin
         cyc();
         n++;
      end
      check(name, 32'(seq_state), 32'(st));
   endtask

   initial begin
      int n;
      bit left;
      reset_vec = {15'd0, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 3'd0, 2'd0, 1'b0};
      reset_reset = 1'b1; perst_n_in = '1; perst_mask = '1; lane_en = '1;
      pll_locked = 1'b0; lane_tx_ready = '0; lane_cdr_locked = '0;
      trace_v = '0; prev_state = '0;

      do_reset();
      check("reset_values", dut_vec(), reset_vec);

      // Nominal bring-up with staggered readiness.
      wait_state(3'd1, 40, "nom_pll_rst");
      n = 0;
      while (pll_reset && n < 40) begin cyc(); n++; end
      check("nom_pll_rst_width", 32'(n), 32'(PR));
      repeat (4) cyc();
      pll_locked = 1'b1;
      wait_state(3'd3, 5, "nom_tx_wait");
      repeat (2) cyc();
      lane_tx_ready = '1;
      wait_state(3'd4, 5, "nom_rx_wait");
      repeat (3) cyc();
      lane_cdr_locked = '1;
      wait_state(3'd5, 5, "nom_core");
      check("nom_core_before_app", 32'({core_reset, app_reset}), 32'(2'b01));
      cyc();
      check("nom_app_release", 32'({seq_state, app_reset}), 32'({3'd6, 1'b0}));
      check("nom_retry", 32'(retry_count), 32'd0);
      check("nom_order", 32'(trace_v[17:0]), 32'({3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}));

      // Lane width / mask vector table: state and lane resets after a fixed run.
      vectors[0] = '{2'b11, 4'b1111, 4'b1111, 3'd6, 4'b0000, 4'b0000, 1'b0};
      vectors[1] = '{2'b01, 4'b0011, 4'b0011, 3'd6, 4'b1100, 4'b1100, 1'b0};
      vectors[2] = '{2'b11, 4'b0000, 4'b0000, 3'd6, 4'b1111, 4'b1111, 1'b0};
      vectors[3] = '{2'b00, 4'b1111, 4'b1111, 3'd6, 4'b0000, 4'b0000, 1'b0};
      vectors[4] = '{2'b11, 4'b1111, 4'b0111, 3'd3, 4'b0000, 4'b1111, 1'b1};
      vectors[5] = '{2'b10, 4'b1001, 4'b1001, 3'd6, 4'b0110, 4'b0110, 1'b0};
      for (int v = 0; v < 6; v++) begin
         perst_n_in = '1; perst_mask = vectors[v].mask; lane_en = vectors[v].en;
         pll_locked = 1'b1;
         lane_tx_ready = vectors[v].rdy; lane_cdr_locked = vectors[v].rdy;
         do_reset();
         repeat (60) cyc();
         check($sformatf("vec%0d", v),
               32'({seq_state, lane_tx_reset, lane_rx_reset, app_reset}),
               32'({vectors[v].exp_state, vectors[v].exp_tx, vectors[v].exp_rx, vectors[v].exp_app}));
      end

      // Timeouts in PLL_WAIT escalate to FAULT; PERST# recovers.
      perst_mask = '1; lane_en = '1; pll_locked = 1'b0;
      do_reset();
      wait_state(3'd2, 60, "tmo_first_wait");
      for (int k = 1; k <= MR + 1; k++) begin
         n = 0;
         while (seq_state == 3'd2 && n < TO + 10) begin cyc(); n++; end
         check($sformatf("tmo_wait_len%0d", k), 32'(n), 32'(TO + 1));
         if (k <= MR) begin
            check($sformatf("tmo_retry%0d", k), 32'({seq_state, retry_count}), 32'({3'd1, 2'(k)}));
            wait_state(3'd2, PR + 4, "tmo_back_to_wait");
         end else begin
            check("tmo_fault", 32'({fault, seq_state, retry_count}), 32'({1'b1, 3'd7, 2'(MR)}));
         end
      end
      perst_n_in[0] = 1'b0;
      wait_state(3'd0, SS + 3, "fault_to_idle");
      check("fault_cleared", 32'({fault, retry_count}), 32'd0);
      perst_n_in = '1;
      wait_state(3'd1, SS + DB + 4, "fault_rebringup");

      // Debounce: masked source toggles, enabled source glitches every 5 cycles.
      perst_mask = 2'b01; perst_n_in = '1;
      do_reset();
      left = 0;
      for (int g = 0; g < 12; g++) begin
         for (int k = 0; k < 5; k++) begin
            perst_n_in[0] = (k != 0);
            perst_n_in[1] = 1'($urandom_range(0, 1));
            cyc();
            if (seq_state != 3'd0) left = 1;
         end
      end
      check("deb_stay_idle", 32'(left), 32'd0);
      n = 4;
      while (seq_state != 3'd1 && n < 40) begin
         perst_n_in[1] = 1'($urandom_range(0, 1));
         cyc();
         n++;
      end
      // Two synchroniser edges, eight quiet cycles, then the FSM edge.
      check("deb_release_delay", 32'(n), 32'(SS + DB + 1));

      // Loss of lock in RUN.
      perst_mask = '1; perst_n_in = '1; pll_locked = 1'b1;
      lane_tx_ready = '1; lane_cdr_locked = '1;
      do_reset();
      wait_state(3'd6, 80, "lol_run");
      lane_cdr_locked[1] = 1'b0;
      cyc();
      check("lol_cdr_resets", 32'({seq_state, core_reset, app_reset, lane_rx_reset}),
            32'({3'd4, 1'b1, 1'b1, 4'hF}));
      repeat (2) cyc();
      lane_cdr_locked = '1;
      wait_state(3'd6, 20, "lol_cdr_recover");
      check("lol_retry", 32'(retry_count), 32'd0);
      pll_locked = 1'b0;
      cyc();
      check("lol_pll", 32'({seq_state, pll_reset, lane_tx_reset, lane_rx_reset, core_reset, app_reset}),
            32'({3'd1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1}));

      // PERST# during TX_WAIT, then reset_reset during RUN.
      pll_locked = 1'b1; lane_tx_ready = '0;
      do_reset();
      wait_state(3'd3, 60, "mid_tx_wait");
      perst_n_in = '0;
      n = 0;
      while (seq_state != 3'd0 && n < 10) begin cyc(); n++; end
      check("mid_perst_latency", 32'(n <= SS + 2), 32'd1);
      check("mid_perst_resets", 32'({pll_reset, lane_tx_reset, lane_rx_reset, core_reset, app_reset}),
            32'(11'h7FF));
      perst_n_in = '1; lane_tx_ready = '1;
      wait_state(3'd6, 60, "mid_run");
      reset_reset = 1'b1;
      cyc();
      check("reset_in_run", dut_vec(), reset_vec);
      reset_reset = 1'b0;

      // Randomized phase against the model.
      for (int s = 0; s < 12; s++) begin
         perst_mask = 2'($urandom_range(1, 3));
         lane_en = 4'($urandom_range(0, 15));
         perst_n_in = '1; pll_locked = 1'b1;
         lane_tx_ready = lane_en; lane_cdr_locked = lane_en;
         do_reset();
         for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 63) == 0) perst_n_in[$urandom_range(0, NP-1)] ^= 1'b1;
            if ($urandom_range(0, 49) == 0) pll_locked = ~pll_locked;
            if ($urandom_range(0, 19) == 0) lane_tx_ready[$urandom_range(0, NL-1)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0) lane_cdr_locked[$urandom_range(0, NL-1)] ^= 1'b1;
            cyc();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
